// File: rtl/mt19937_pkg.sv
// Shared constants, index type and FSM encoding for the MT19937 generator.
package mt19937_pkg;

    localparam int unsigned N = 624;
    localparam int unsigned M = 397;

    typedef logic [9:0] idx_t;

    localparam idx_t        LAST_IDX = idx_t'(N - 1);
    localparam logic [10:0] N_WIDE   = 11'(N);

    localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] INIT_MULT  = 32'd1812433253;

    localparam int unsigned INIT_SHIFT = 30;

    localparam int unsigned TEMPER_U = 11;
    localparam int unsigned TEMPER_S = 7;
    localparam int unsigned TEMPER_T = 15;
    localparam int unsigned TEMPER_L = 18;
    localparam logic [31:0] TEMPER_B = 32'h9D2C_5680;
    localparam logic [31:0] TEMPER_C = 32'hEFC6_0000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    // (i + k) mod N for i < N and k < N, without a divider.
    function automatic idx_t wrap_add(input idx_t i, input int unsigned k);
        logic [10:0] sum;
        sum = {1'b0, i} + 11'(k);
        if (sum >= N_WIDE) begin
            sum = sum - N_WIDE;
        end
        return idx_t'(sum);
    endfunction

endpackage

// File: rtl/mt19937_temper.sv
// MT19937 output tempering: a fixed xor-shift-mask bijection on one word.
module mt19937_temper
    import mt19937_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] t3;

    assign t1   = din ^ (din >> TEMPER_U);
    assign t2   = t1 ^ ((t1 << TEMPER_S) & TEMPER_B);
    assign t3   = t2 ^ ((t2 << TEMPER_T) & TEMPER_C);
    assign dout = t3 ^ (t3 >> TEMPER_L);

endmodule

// File: rtl/mt19937.sv
// MT19937 generator: serial seeding, then one in-place twist and one
// tempered output word per clock.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | expanding the seed, one mt[idx] per cycle, idx 1..623
//   ST_GEN  | twisting mt[idx] in place and emitting temper(x) each cycle
module mt19937
    import mt19937_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        re_seed,
    output logic [31:0] rnd,
    output logic        rnd_valid
);

    logic [31:0] mt [N];

    state_t      state;
    state_t      state_next;
    idx_t        idx;
    idx_t        idx_next;
    logic [31:0] rnd_next;
    logic        valid_next;

    logic        wr_en;
    idx_t        wr_addr;
    logic [31:0] wr_data;

    idx_t        rd_a_addr;
    idx_t        idx_succ;
    idx_t        idx_far;
    logic [31:0] word_a;
    logic [31:0] word_succ;
    logic [31:0] word_far;

    logic [31:0] init_word;
    logic [31:0] y;
    logic [31:0] x;
    logic [31:0] x_tempered;

    // Read port A serves mt[idx-1] while seeding and mt[idx] while
    // generating, so the array only ever needs three read ports.
    assign rd_a_addr = (state == ST_INIT) ? (idx - 10'd1) : idx;
    assign idx_succ  = wrap_add(idx, 1);
    assign idx_far   = wrap_add(idx, M);

    assign word_a    = mt[rd_a_addr];
    assign word_succ = mt[idx_succ];
    assign word_far  = mt[idx_far];

    assign init_word = INIT_MULT * (word_a ^ (word_a >> INIT_SHIFT)) + {22'd0, idx};

    // Entries already rewritten this round are read back on wrap, which is
    // exactly what the reference in-place twist does.
    assign y = (word_a & UPPER_MASK) | (word_succ & LOWER_MASK);
    assign x = word_far ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'd0);

    mt19937_temper u_temper (
        .din  (x),
        .dout (x_tempered)
    );

    // Next-state, array write and output selection; a seed request overrides everything.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        rnd_next   = rnd;
        valid_next = rnd_valid;
        wr_en      = 1'b0;
        wr_addr    = idx;
        wr_data    = x;

        if (rst || re_seed) begin
            state_next = ST_INIT;
            idx_next   = 10'd1;
            rnd_next   = '0;
            valid_next = 1'b0;
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_data    = seed;
        end else begin
            case (state)
                ST_INIT: begin
                    wr_en   = 1'b1;
                    wr_data = init_word;
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ST_GEN;
                    end else begin
                        idx_next = idx + 10'd1;
                    end
                end
                ST_GEN: begin
                    wr_en      = 1'b1;
                    wr_data    = x;
                    rnd_next   = x_tempered;
                    valid_next = 1'b1;
                    idx_next   = idx_succ;
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            idx       <= 10'd1;
            rnd       <= '0;
            rnd_valid <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            rnd       <= rnd_next;
            rnd_valid <= valid_next;
        end
    end

    // State array: single write port; only mt[0] is touched by a seed edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mt[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mt19937.sv
// Scoreboard bench for mt19937: a batch-twist reference model fills an
// expectation queue after each seed edge, a negedge monitor drains it.
module tb_mt19937;

    logic        clk;
    logic        rst;
    logic        re_seed;
    logic [31:0] seed;
    logic [31:0] rnd;
    logic        rnd_valid;

    int errors;
    int checks;

    logic [31:0] exp_q [$];

    logic [31:0] ref_mt [624];
    int          ref_pos;

    mt19937 dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .re_seed   (re_seed),
        .rnd       (rnd),
        .rnd_valid (rnd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_temper(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v >> 11);
        t = t ^ ((t << 7) & 32'h9D2C5680);
        t = t ^ ((t << 15) & 32'hEFC60000);
        t = t ^ (t >> 18);
        return t;
    endfunction

    task automatic ref_seed(input logic [31:0] s);
        ref_mt[0] = s;
        for (int i = 1; i < 624; i++) begin
            ref_mt[i] = 32'd1812433253 * (ref_mt[i-1] ^ (ref_mt[i-1] >> 30)) + 32'(i);
        end
        ref_pos = 624;
    endtask

    // Classic whole-block regeneration, as in the original C reference.
    task automatic ref_twist();
        logic [31:0] yv;
        for (int i = 0; i < 624; i++) begin
            yv = (ref_mt[i] & 32'h80000000) | (ref_mt[(i + 1) % 624] & 32'h7FFFFFFF);
            ref_mt[i] = ref_mt[(i + 397) % 624] ^ (yv >> 1) ^ ((yv & 32'd1) != 0 ? 32'h9908B0DF : 32'd0);
        end
        ref_pos = 0;
    endtask

    task automatic ref_next(output logic [31:0] v);
        if (ref_pos >= 624) ref_twist();
        v = ref_temper(ref_mt[ref_pos]);
        ref_pos++;
    endtask

    task automatic load_expect(input logic [31:0] s, input int n);
        logic [31:0] v;
        ref_seed(s);
        for (int i = 0; i < n; i++) begin
            ref_next(v);
            exp_q.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic seed_edge(input logic r, input logic rs, input logic [31:0] s);
        seed    = s;
        rst     = r;
        re_seed = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic release_inputs();
        rst     = 1'b0;
        re_seed = 1'b0;
        seed    = $urandom;
    endtask

    task automatic check_cleared(input string name);
        check({name, " rnd"}, rnd, 32'd0);
        check({name, " rnd_valid"}, {31'd0, rnd_valid}, 32'd0);
    endtask

    // Counts edges after the seed edge until rnd_valid rises; rnd must stay 0 meanwhile.
    task automatic check_latency(input string name);
        int   k;
        logic zero_ok;
        k       = 0;
        zero_ok = 1'b1;
        while (k < 700) begin
            @(posedge clk);
            #1;
            k++;
            if (rnd_valid) break;
            if (rnd != 32'd0) zero_ok = 1'b0;
        end
        check({name, " latency"}, 32'(k), 32'd624);
        check({name, " rnd zero in init"}, {31'd0, zero_ok}, 32'd1);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < 12000) begin
            @(posedge clk);
            c++;
        end
        check({name, " words left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every valid word while expectations are pending is compared.
    always @(negedge clk) begin
        logic [31:0] want;
        if (rnd_valid === 1'b1 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("rnd word", rnd, want);
        end
    end

    initial begin
        logic [31:0] s;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [31:0] sc;

        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        re_seed = 1'b0;
        seed    = 32'd0;
        repeat (3) @(posedge clk);
        #1;

        // Default seed via reset, long run across many index wraps.
        seed_edge(1'b1, 1'b0, 32'd5489);
        release_inputs();
        check_cleared("rst 5489");
        load_expect(32'd5489, 10000);
        exp_q[0]    = 32'd3499211612;
        exp_q[1]    = 32'd581869302;
        exp_q[2]    = 32'd3890346734;
        exp_q[9999] = 32'd4123659995;
        check_latency("rst 5489");
        drain("rst 5489");

        // Reseed from GEN with the same seed: sequence restarts.
        seed_edge(1'b0, 1'b1, 32'd5489);
        release_inputs();
        check_cleared("re_seed in gen");
        load_expect(32'd5489, 40);
        exp_q[0] = 32'd3499211612;
        exp_q[1] = 32'd581869302;
        exp_q[2] = 32'd3890346734;
        check_latency("re_seed in gen");
        drain("re_seed in gen");

        // Seed 1.
        seed_edge(1'b0, 1'b1, 32'd1);
        release_inputs();
        check_cleared("seed 1");
        load_expect(32'd1, 20);
        exp_q[0] = 32'd1791095845;
        exp_q[1] = 32'd4282876139;
        check_latency("seed 1");
        drain("seed 1");

        // Reseed in the middle of initialization.
        seed_edge(1'b0, 1'b1, $urandom);
        release_inputs();
        repeat (299) @(posedge clk);
        #1;
        s = $urandom;
        seed_edge(1'b0, 1'b1, s);
        release_inputs();
        check_cleared("re_seed in init");
        load_expect(s, 30);
        check_latency("re_seed in init");
        drain("re_seed in init");

        // rst and re_seed together, seed changing every edge: last one wins.
        sa = $urandom;
        sb = $urandom;
        sc = $urandom;
        seed_edge(1'b1, 1'b1, sa);
        seed_edge(1'b1, 1'b1, sb);
        seed_edge(1'b1, 1'b1, sc);
        release_inputs();
        check_cleared("rst+re_seed");
        load_expect(sc, 30);
        check_latency("rst+re_seed");
        drain("rst+re_seed");

        // Level-held re_seed keeps restarting.
        for (int k = 0; k < 5; k++) begin
            s = $urandom;
            seed_edge(1'b0, 1'b1, s);
        end
        release_inputs();
        check_cleared("re_seed level");
        load_expect(s, 30);
        check_latency("re_seed level");
        drain("re_seed level");

        // A few random seeds via reset.
        for (int k = 0; k < 3; k++) begin
            s = $urandom;
            seed_edge(1'b1, 1'b0, s);
            release_inputs();
            check_cleared("rst random");
            load_expect(s, 40);
            check_latency("rst random");
            drain("rst random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mt19937.md
MT19937 -- requirements
Module: mt19937

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset; reseeds from seed.
REQ-004 seed  input  32  seed value, sampled only in a cycle where rst or re_seed is high.
REQ-005 re_seed  input  1  synchronous reseed request, single-cycle pulse or level.
REQ-006 rnd  output  32  registered tempered MT19937 output word.
REQ-007 rnd_valid  output  1  high when rnd holds a valid generated word; may be left unconnected.
REQ-008 Parameters: none; N=624, M=397 and all constants are fixed.

Function
REQ-009 State: 624 x 32-bit array mt[], index idx 0..623, FSM states INIT and GEN.
REQ-010 Seed edge (rst high, or re_seed high with rst low): mt[0]<=seed, idx<=1, state<=INIT, rnd<=0, rnd_valid<=0.
REQ-011 INIT, one word per cycle: mt[idx] <= 1812433253*(mt[idx-1]^(mt[idx-1]>>30)) + idx, product truncated to low 32 bits.
REQ-012 INIT: idx increments each cycle; after writing mt[623], idx<=0 and state<=GEN (623 INIT cycles).
REQ-013 GEN, every cycle, no enable: y = (mt[idx]&0x80000000)|(mt[(idx+1)%624]&0x7FFFFFFF); x = mt[(idx+397)%624]^(y>>1)^(y[0] ? 0x9908B0DF : 0).
REQ-014 GEN: mt[idx]<=x; rnd<=temper(x); rnd_valid<=1; idx<=(idx==623)?0:idx+1.
REQ-015 Temper: t=x^(x>>11); t^=(t<<7)&0x9D2C5680; t^=(t<<15)&0xEFC60000; t^=t>>18.
REQ-016 The in-place twist reads already-updated entries on wrap (idx>=227 for the +397 term, idx=623 for the +1 term); the output sequence is bit-exact to reference MT19937 (std::mt19937) for the same seed.
REQ-017 First valid rnd appears after the 624th rising edge following the seed edge; one new word every cycle thereafter, indefinitely.
REQ-018 re_seed during INIT or GEN restarts initialization immediately; a level-held re_seed keeps restarting.
REQ-019 rst has priority over re_seed; both use the current seed input.
REQ-020 rnd holds 0 and rnd_valid holds 0 throughout INIT.

Reset
REQ-021 rst high at a rising edge performs REQ-010; there is no separate power-on default beyond that.
REQ-022 rst asserted mid-INIT or mid-GEN discards all progress; mt[] contents other than mt[0] need not be cleared.
REQ-023 Before the first reset, outputs are undefined; the bench must reset first.

Structure
REQ-024 Package mt19937_pkg holds: N=624, M=397, MATRIX_A=0x9908B0DF, UPPER_MASK=0x80000000, LOWER_MASK=0x7FFFFFFF, INIT_MULT=1812433253, tempering masks/shifts, and the FSM state enum.
REQ-025 One combinational sub-module mt19937_temper (32-bit in, 32-bit out) implements REQ-015.
REQ-026 The state array is a register array with three reads and one write per cycle; no RAM macro is required.
REQ-027 The Xilinx glbl module is instantiated only by gate-level benches and is not part of this block.

Verification
REQ-028 seed=5489, pulse rst -> rnd_valid rises 624 edges later; first three rnd = 3499211612, 581869302, 3890346734.
REQ-029 seed=1, pulse rst -> first two rnd = 1791095845, 4282876139.
REQ-030 Run seed=5489 for 10000 GEN cycles -> 10000th rnd = 4123659995, exercising index wrap.
REQ-031 In GEN, set seed=5489 and pulse re_seed -> rnd_valid drops next edge, rnd=0, then REQ-028 sequence repeats.
REQ-032 Pulse re_seed at INIT cycle 300 -> completes 624 edges after the second pulse with the correct sequence for the new seed.
REQ-033 rst and re_seed high together with different seed changes across cycles -> behaves as reset using the seed present at the last asserted edge.
